// File: rtl/jtag_vector_player.sv
// Vector player for the PMU TAP: replays TDI/TMS from a loadable store after a reset
// preamble, optionally compares returned TDO against expected/mask vectors, and can
// repeat the sequence back-to-back.
`timescale 1ns/1ps
module jtag_vector_player #(
    parameter int unsigned MAX_BITS = 1024,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RST_CYC  = 1,
    parameter int unsigned ERR_W    = 16,
    localparam int unsigned LW      = $clog2(MAX_BITS + 1),
    localparam int unsigned AW      = $clog2(MAX_BITS / DATA_W)
) (
    input  logic              tck_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [AW-1:0]     cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_wdata_i,
    input  logic [LW-1:0]     len_i,
    input  logic [7:0]        loops_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              pause_i,
    input  logic              tdo_i,
    output logic              tms_o,
    output logic              tdi_o,
    output logic              dut_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [LW-1:0]     first_err_o,
    output logic [LW-1:0]     bit_idx_o
);
    localparam int unsigned OW = $clog2(DATA_W);
    localparam int unsigned BW = $clog2(MAX_BITS);
    localparam int unsigned CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {StIdle, StRstLo, StRstHi, StPlay, StDone} state_e;

    state_e state_q, state_d;

    logic [MAX_BITS-1:0] tdi_mem, tms_mem, exp_mem, mask_mem;
    logic [BW-1:0]       wr_base, rd_idx;

    logic [LW-1:0]    bit_q, bit_d, len_q, len_d, first_q, first_d;
    logic [7:0]       pass_rem_q, pass_rem_d;
    logic [CW-1:0]    rst_cnt_q, rst_cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             tdi_q, tdi_d, tms_q, tms_d, dut_rst_q, dut_rst_d;
    logic             rst_last, bit_last, busy;

    assign busy     = (state_q == StRstLo) || (state_q == StRstHi) || (state_q == StPlay);
    assign rst_last = (rst_cnt_q == CW'(RST_CYC - 1));
    assign bit_last = (bit_q == len_q - 1'b1);
    assign wr_base  = {cfg_addr_i, OW'(0)};
    assign rd_idx   = bit_q[BW-1:0];

    // Vector store: no reset, writes only while idle so a running sequence is stable.
    always_ff @(posedge tck_i) begin
        if (cfg_we_i && !busy) begin
            case (cfg_sel_i)
                2'd0:    tdi_mem[wr_base +: DATA_W]  <= cfg_wdata_i;
                2'd1:    tms_mem[wr_base +: DATA_W]  <= cfg_wdata_i;
                2'd2:    exp_mem[wr_base +: DATA_W]  <= cfg_wdata_i;
                default: mask_mem[wr_base +: DATA_W] <= cfg_wdata_i;
            endcase
        end
    end

    // State register.
    always_ff @(posedge tck_i or negedge rst_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next state: abort wins, pause freezes every non-idle state.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else if (state_q == StIdle) begin
            if (start_i) state_d = StRstLo;
        end else if (!pause_i) begin
            case (state_q)
                StRstLo: if (rst_last) state_d = StRstHi;
                StRstHi: if (rst_last) state_d = (len_q == '0) ? StDone : StPlay;
                StPlay:  if (bit_last && (pass_rem_q == 8'd1)) state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath next values: counters, TDO compare, result flags and pin values.
    always_comb begin
        bit_d      = bit_q;
        len_d      = len_q;
        pass_rem_d = pass_rem_q;
        rst_cnt_d  = rst_cnt_q;
        err_d      = err_q;
        first_d    = first_q;
        pass_d     = pass_q;
        if (abort_i) begin
            if (state_q != StIdle) begin
                bit_d     = '0;
                rst_cnt_d = '0;
                pass_d    = 1'b0;
            end
        end else if (state_q == StIdle) begin
            if (start_i) begin
                len_d      = (len_i > LW'(MAX_BITS)) ? LW'(MAX_BITS) : len_i;
                pass_rem_d = (loops_i == 8'd0) ? 8'd1 : loops_i;
                err_d      = '0;
                first_d    = '1;
                pass_d     = 1'b0;
                bit_d      = '0;
                rst_cnt_d  = '0;
            end
        end else if (!pause_i) begin
            case (state_q)
                StRstLo, StRstHi: rst_cnt_d = rst_last ? '0 : rst_cnt_q + 1'b1;
                StPlay: begin
                    if (mask_mem[rd_idx] && (tdo_i != exp_mem[rd_idx])) begin
                        if (err_q != '1)   err_d   = err_q + 1'b1;
                        if (first_q == '1) first_d = bit_q;
                    end
                    if (bit_last) begin
                        bit_d = '0;
                        if (pass_rem_q != 8'd1) pass_rem_d = pass_rem_q - 8'd1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                default: ;
            endcase
            if ((state_d == StDone) && (state_q != StDone)) pass_d = (err_d == '0);
        end
        // Pins are registered from the state being entered, so a pause simply re-registers
        // the same bit.
        tdi_d     = 1'b0;
        tms_d     = 1'b0;
        dut_rst_d = (state_d != StRstLo);
        if (state_d == StPlay) begin
            tdi_d = tdi_mem[bit_d[BW-1:0]];
            tms_d = tms_mem[bit_d[BW-1:0]];
        end
    end

    // Datapath and output registers.
    always_ff @(posedge tck_i or negedge rst_i) begin
        if (!rst_i) begin
            bit_q      <= '0;
            len_q      <= '0;
            pass_rem_q <= 8'd1;
            rst_cnt_q  <= '0;
            err_q      <= '0;
            first_q    <= '1;
            pass_q     <= 1'b0;
            tdi_q      <= 1'b0;
            tms_q      <= 1'b0;
            dut_rst_q  <= 1'b1;
        end else begin
            bit_q      <= bit_d;
            len_q      <= len_d;
            pass_rem_q <= pass_rem_d;
            rst_cnt_q  <= rst_cnt_d;
            err_q      <= err_d;
            first_q    <= first_d;
            pass_q     <= pass_d;
            tdi_q      <= tdi_d;
            tms_q      <= tms_d;
            dut_rst_q  <= dut_rst_d;
        end
    end

    assign tdi_o       = tdi_q;
    assign tms_o       = tms_q;
    assign dut_rst_o   = dut_rst_q;
    assign busy_o      = busy;
    assign done_o      = (state_q == StDone);
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_q;
    assign first_err_o = first_q;
    assign bit_idx_o   = bit_q;
endmodule

// File: tb/tb_jtag_vector_player.sv
// Randomised scoreboard bench for jtag_vector_player: the driver plays each run cycle by
// cycle and queues expected bits/results from a plain array model; a negedge monitor checks.
`timescale 1ns/1ps
module tb_jtag_vector_player;
    localparam int MAX_BITS = 1024;
    localparam int DATA_W   = 32;
    localparam int RST_CYC  = 1;
    localparam int ERR_W    = 16;
    localparam int LW       = $clog2(MAX_BITS + 1);
    localparam int AW       = $clog2(MAX_BITS / DATA_W);
    localparam int NW       = MAX_BITS / DATA_W;
    localparam int FIRST_NONE = (1 << LW) - 1;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    typedef struct { logic tdi; logic tms; int idx; } bit_t;
    typedef struct { int err; int first; logic pass; int cyc; } res_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cfg_we_i = 1'b0, start_i = 1'b0, abort_i = 1'b0, pause_i = 1'b0, tdo_i = 1'b0;
    logic [1:0] cfg_sel_i = '0;
    logic [AW-1:0] cfg_addr_i = '0;
    logic [DATA_W-1:0] cfg_wdata_i = '0;
    logic [LW-1:0] len_i = '0;
    logic [7:0] loops_i = '0;
    logic tms_o, tdi_o, dut_rst_o, busy_o, done_o, pass_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic [LW-1:0] first_err_o, bit_idx_o;

    jtag_vector_player #(.MAX_BITS(MAX_BITS), .DATA_W(DATA_W), .RST_CYC(RST_CYC),
                         .ERR_W(ERR_W)) dut (
        .tck_i(clk), .rst_i(rst_n), .cfg_we_i(cfg_we_i), .cfg_sel_i(cfg_sel_i),
        .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .len_i(len_i),
        .loops_i(loops_i), .start_i(start_i), .abort_i(abort_i), .pause_i(pause_i),
        .tdo_i(tdo_i), .tms_o(tms_o), .tdi_o(tdi_o), .dut_rst_o(dut_rst_o),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
        .first_err_o(first_err_o), .bit_idx_o(bit_idx_o)
    );

    always #5 clk = ~clk;

    bit tdi_m[MAX_BITS], tms_m[MAX_BITS], exp_m[MAX_BITS], mask_m[MAX_BITS];
    bit_t exp_q[$];
    res_t res_q[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0;
    logic held = 1'b0;
    int pre_left = 0;
    bit have_last = 1'b0;
    bit_t last;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        held <= pause_i;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: play bits are the busy cycles after the reset preamble.
    always @(negedge clk) begin
        bit_t e;
        res_t r;
        if (rst_n) begin
            if (!dut_rst_o) begin
                pre_left = RST_CYC;
            end else if (busy_o) begin
                if (held) begin
                    if (have_last) begin
                        chk("hold_tdi", tdi_o, last.tdi);
                        chk("hold_tms", tms_o, last.tms);
                        chk("hold_idx", bit_idx_o, last.idx);
                    end
                end else if (pre_left > 0) begin
                    pre_left--;
                end else if (exp_q.size() == 0) begin
                    flag("unexpected_play_cycle");
                end else begin
                    e = exp_q.pop_front();
                    last = e;
                    have_last = 1'b1;
                    chk("tdi", tdi_o, e.tdi);
                    chk("tms", tms_o, e.tms);
                    chk("bit_idx", bit_idx_o, e.idx);
                end
            end
            if (done_o) begin
                if (res_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    r = res_q.pop_front();
                    chk("err_cnt", err_cnt_o, r.err);
                    chk("first_err", first_err_o, r.first);
                    chk("pass", pass_o, r.pass);
                    chk("done_cycle", cyc, r.cyc);
                    chk("done_busy", busy_o, 0);
                    chk("done_tdi_tms", {tdi_o, tms_o}, 0);
                end
            end
        end
    end

    task automatic chk_reset();
        chk("rst_tms", tms_o, 0);
        chk("rst_tdi", tdi_o, 0);
        chk("rst_dut_rst", dut_rst_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_first", first_err_o, FIRST_NONE);
        chk("rst_bit_idx", bit_idx_o, 0);
    endtask

    // mode 0 random, 1 zeros, 2 only bits 5 and 9 set.
    task automatic load(input int sel, input int mode);
        logic [DATA_W-1:0] d;
        for (int w = 0; w < NW; w++) begin
            if (mode == 0)      d = DATA_W'($urandom);
            else if (mode == 1) d = '0;
            else                d = (w == 0) ? DATA_W'(32'h220) : '0;
            cfg_we_i = 1'b1; cfg_sel_i = 2'(sel); cfg_addr_i = AW'(w); cfg_wdata_i = d;
            @(posedge clk); #1;
            cfg_we_i = 1'b0;
            for (int b = 0; b < DATA_W; b++) begin
                case (sel)
                    0: tdi_m[w*DATA_W+b] = d[b];
                    1: tms_m[w*DATA_W+b] = d[b];
                    2: exp_m[w*DATA_W+b] = d[b];
                    default: mask_m[w*DATA_W+b] = d[b];
                endcase
            end
        end
    endtask

    // One run; called and returns at posedge+1. Negative step arguments disable a feature.
    task automatic run(input int len, input int loops, input int tdo_fix, input int pause_at,
                       input int pause_len, input int abort_at, input int rst_at,
                       input bit poke);
        int eff, np, err, first, sc, step;
        bit t;
        bit_t e;
        res_t r;
        logic [DATA_W-1:0] w0;
        eff = (len > MAX_BITS) ? MAX_BITS : len;
        np  = (loops == 0) ? 1 : loops;
        err = 0; first = -1;
        for (int b = 0; b < DATA_W; b++) w0[b] = tdi_m[b];
        len_i = LW'(len); loops_i = 8'(loops); start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        sc = cyc;
        repeat (2*RST_CYC - 1) @(posedge clk);
        #1;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < eff; i++) begin
                @(posedge clk); #1;
                start_i = 1'b0; cfg_we_i = 1'b0;
                step = p*eff + i;
                e.tdi = tdi_m[i]; e.tms = tms_m[i]; e.idx = i;
                exp_q.push_back(e);
                if (step == rst_at) begin
                    #1 rst_n = 1'b0;
                    exp_q.delete();
                    #1 chk_reset();
                    @(posedge clk); #3 rst_n = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
                if (step == abort_at) begin
                    tdo_i = exp_m[i];
                    abort_i = 1'b1;
                    @(posedge clk); #1;
                    abort_i = 1'b0;
                    chk("abort_busy", busy_o, 0);
                    chk("abort_dut_rst", dut_rst_o, 1);
                    chk("abort_tdi_tms", {tdi_o, tms_o}, 0);
                    chk("abort_pass", pass_o, 0);
                    chk("abort_err", err_cnt_o, err);
                    chk("abort_first", first_err_o, (first < 0) ? FIRST_NONE : first);
                    repeat (4) @(posedge clk);
                    #1 chk("abort_bits_shown", exp_q.size(), 0);
                    exp_q.delete();
                    return;
                end
                if (poke && step == 3) begin
                    start_i = 1'b1; cfg_we_i = 1'b1; cfg_sel_i = 2'd0; cfg_addr_i = '0;
                    cfg_wdata_i = ~w0;
                end
                if (step == pause_at) begin
                    pause_i = 1'b1;
                    repeat (pause_len) begin
                        tdo_i = 1'($urandom);
                        @(posedge clk); #1;
                    end
                    pause_i = 1'b0;
                end
                t = (tdo_fix >= 0) ? tdo_fix[0] : 1'($urandom);
                tdo_i = t;
                if (mask_m[i] && (t != exp_m[i])) begin
                    err++;
                    if (first < 0) first = i;
                end
            end
        end
        r.err   = (err > ERR_MAX) ? ERR_MAX : err;
        r.first = (first < 0) ? FIRST_NONE : first;
        r.pass  = (err == 0);
        r.cyc   = sc + 2*RST_CYC + eff*np + ((pause_at >= 0) ? pause_len : 0);
        res_q.push_back(r);
        for (int k = 0; k < 100 && res_q.size() != 0; k++) @(posedge clk);
        if (res_q.size() != 0) begin
            flag("done_timeout");
            res_q.delete();
            exp_q.delete();
        end
        start_i = 1'b0; cfg_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int l, lp, pa;
        repeat (2) @(posedge clk);
        #1 chk_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;

        load(0, 0); load(1, 0); load(2, 0); load(3, 1);
        run(547, 1, -1, -1, 0, -1, -1, 1'b0);              // key-load, mask off
        chk("t1_pass", pass_o, 1);

        load(2, 1); load(3, 2);
        run(16, 1, 1, -1, 0, -1, -1, 1'b0);
        chk("t2_err", err_cnt_o, 2);
        chk("t2_first", first_err_o, 5);
        chk("t2_pass", pass_o, 0);
        run(16, 3, 1, -1, 0, -1, -1, 1'b0);
        chk("t3_err", err_cnt_o, 6);
        chk("t3_first", first_err_o, 5);

        load(2, 0); load(3, 0);
        run(32, 1, -1, 10, 4, -1, -1, 1'b0);               // pause at bit 10
        run(32, 1, -1, -1, 0, 20, -1, 1'b1);               // abort + dropped write
        run(32, 1, -1, -1, 0, -1, -1, 1'b0);               // re-run, original vectors
        run(0, 1, -1, -1, 0, -1, -1, 1'b0);                // preamble only
        chk("t6_pass", pass_o, 1);
        run(5, 0, -1, -1, 0, -1, -1, 1'b0);                // loops 0 -> 1
        run(1500, 1, -1, -1, 0, -1, -1, 1'b0);             // clamp to MAX_BITS

        repeat (8) begin
            l  = $urandom_range(0, 80);
            lp = $urandom_range(0, 3);
            pa = ((l > 0) && ($urandom_range(0, 1) == 1)) ?
                 $urandom_range(0, l*((lp == 0) ? 1 : lp) - 1) : -1;
            run(l, lp, -1, pa, $urandom_range(1, 3), -1, -1,
                (l*((lp == 0) ? 1 : lp) > 4) && ($urandom_range(0, 1) == 1));
        end

        run(40, 1, -1, -1, 0, -1, 15, 1'b0);               // async reset mid-play
        run(8, 2, -1, -1, 0, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
